// File: rtl/instr_sequencer.sv
// MSP430 front-end sequencer: fetches the reset vector, instruction and
// extension words, classifies the opcode and steps CAR through the micro-sequence.
module instr_sequencer #(
  parameter int                  CAR_BITS   = 6,
  parameter logic [CAR_BITS-1:0] ENTRY_FMT1 = 'd1,
  parameter logic [CAR_BITS-1:0] ENTRY_FMT2 = 'd22,
  parameter logic [CAR_BITS-1:0] ENTRY_JMP  = 'd59,
  parameter logic [CAR_BITS-1:0] ENTRY_INT  = 'd50,
  parameter logic [15:0]         RESET_VEC  = 16'hFFFE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         MDB,
  input  logic                MDB_valid,
  input  logic                uop_last,
  input  logic                pc_load,
  input  logic [15:0]         pc_new,
  input  logic                INTREQ,
  input  logic                GIE,
  output logic [15:0]         MAB,
  output logic                MAB_req,
  output logic [15:0]         PC,
  output logic [15:0]         IR,
  output logic [CAR_BITS-1:0] CAR,
  output logic [15:0]         SrcExt,
  output logic [15:0]         DstExt,
  output logic                INTACK,
  output logic                ILLEGAL
);

  typedef enum logic [2:0] {S_VEC, S_FETCH, S_DECODE, S_SRCX, S_DSTX, S_EXEC} state_t;

  state_t              state, state_nxt;
  logic [15:0]         pc_nxt, ir_nxt, srcx_nxt, dstx_nxt;
  logic [CAR_BITS-1:0] car_nxt, entry_q, entry_nxt;
  logic                dst_q, dst_nxt, intack_nxt, illegal_nxt;

  // opcode classification, only meaningful while IR holds a fresh word
  logic       is_jmp, is_f2, is_f1, is_reti, src_x, dst_x;
  logic [3:0] rs;
  logic [1:0] as_mode;

  always_comb begin
    is_jmp  = (IR[15:13] == 3'b001);
    is_f2   = (IR[15:10] == 6'b000100) && (IR[9:7] != 3'b111);
    is_f1   = (IR[15:12] >= 4'd4);
    is_reti = is_f2 && (IR[9:7] == 3'b110);
    rs      = is_f2 ? IR[3:0] : IR[11:8];
    as_mode = IR[5:4];
    // R3 with As=01 is the constant generator, not an indexed operand
    src_x   = !is_reti && (((as_mode == 2'b01) && (rs != 4'd3)) ||
                           ((as_mode == 2'b11) && (rs == 4'd0)));
    dst_x   = is_f1 && IR[7];
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = PC;
    ir_nxt      = IR;
    car_nxt     = CAR;
    srcx_nxt    = SrcExt;
    dstx_nxt    = DstExt;
    entry_nxt   = entry_q;
    dst_nxt     = dst_q;
    intack_nxt  = 1'b0;
    illegal_nxt = 1'b0;
    MAB         = PC;
    MAB_req     = 1'b0;
    case (state)
      S_VEC: begin
        MAB     = RESET_VEC;
        MAB_req = 1'b1;
        if (MDB_valid) begin
          pc_nxt    = MDB;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        MAB_req = 1'b1;
        if (MDB_valid) begin
          pc_nxt    = PC + 16'd2;
          ir_nxt    = MDB;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_jmp) begin
          car_nxt   = ENTRY_JMP;
          state_nxt = S_EXEC;
        end else if (is_f2 || is_f1) begin
          entry_nxt = is_f2 ? ENTRY_FMT2 : ENTRY_FMT1;
          dst_nxt   = dst_x;
          if (src_x)      state_nxt = S_SRCX;
          else if (dst_x) state_nxt = S_DSTX;
          else begin
            car_nxt   = is_f2 ? ENTRY_FMT2 : ENTRY_FMT1;
            state_nxt = S_EXEC;
          end
        end else begin
          illegal_nxt = 1'b1;
          car_nxt     = '0;
          state_nxt   = S_FETCH;
        end
      end
      S_SRCX: begin
        MAB_req = 1'b1;
        if (MDB_valid) begin
          pc_nxt   = PC + 16'd2;
          srcx_nxt = MDB;
          if (dst_q) state_nxt = S_DSTX;
          else begin
            car_nxt   = entry_q;
            state_nxt = S_EXEC;
          end
        end
      end
      S_DSTX: begin
        MAB_req = 1'b1;
        if (MDB_valid) begin
          pc_nxt    = PC + 16'd2;
          dstx_nxt  = MDB;
          car_nxt   = entry_q;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (pc_load) pc_nxt = pc_new;
        if (!uop_last) car_nxt = CAR + CAR_BITS'(1);
        else if (INTREQ && GIE) begin
          car_nxt    = ENTRY_INT;
          intack_nxt = 1'b1;
        end else begin
          car_nxt   = '0;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_VEC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_VEC;
      PC      <= '0;
      IR      <= '0;
      CAR     <= '0;
      SrcExt  <= '0;
      DstExt  <= '0;
      entry_q <= '0;
      dst_q   <= 1'b0;
      INTACK  <= 1'b0;
      ILLEGAL <= 1'b0;
    end else begin
      state   <= state_nxt;
      PC      <= pc_nxt;
      IR      <= ir_nxt;
      CAR     <= car_nxt;
      SrcExt  <= srcx_nxt;
      DstExt  <= dstx_nxt;
      entry_q <= entry_nxt;
      dst_q   <= dst_nxt;
      INTACK  <= intack_nxt;
      ILLEGAL <= illegal_nxt;
    end
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Front-end sequencer for the MSP430 CPU that produces the `CAR` and `IR` values the control unit decodes. It fetches the reset vector and then instruction words and extension words from memory, maintains `PC`, classifies each opcode, and steps `CAR` through the micro-sequence until the control store flags the last micro-step. At instruction boundaries it takes pending interrupts and pulses `INTACK`.

## Interface
- `CAR_BITS`, 6: width of the control address register.
- `ENTRY_FMT1`, 1: `CAR` entry point for Format I (two-operand) instructions.
- `ENTRY_FMT2`, 22: `CAR` entry point for Format II (single-operand) instructions.
- `ENTRY_JMP`, 59: `CAR` entry point for jumps.
- `ENTRY_INT`, 50: `CAR` entry point for the interrupt-entry micro-sequence.
- `RESET_VEC`, 16'hFFFE: address of the reset vector.

Ports (clock first; reset is synchronous and active-high):
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `MDB` in 16: memory data bus.
- `MDB_valid` in 1: `MDB` holds the word requested at `MAB`.
- `uop_last` in 1: the current `CAR` is the final micro-step (from the control store).
- `pc_load` in 1: the datapath writes `PC` this cycle.
- `pc_new` in 16: value written to `PC` when `pc_load` is set.
- `INTREQ` in 1: maskable interrupt pending.
- `GIE` in 1: global interrupt enable (SR bit 3).
- `MAB` out 16: fetch address.
- `MAB_req` out 1: fetch request.
- `PC` out 16: program counter.
- `IR` out 16: instruction register.
- `CAR` out CAR_BITS: control address.
- `SrcExt` out 16: latched source extension word.
- `DstExt` out 16: latched destination extension word.
- `INTACK` out 1: one-cycle interrupt acknowledge.
- `ILLEGAL` out 1: one-cycle pulse when an illegal opcode is skipped.

## Operation
- States: `S_VEC`, `S_FETCH`, `S_DECODE`, `S_SRCX`, `S_DSTX`, `S_EXEC`.
- `S_VEC`: `MAB = RESET_VEC`, `MAB_req = 1`. When `MDB_valid` is set, `PC <= MDB` and the next state is `S_FETCH`.
- `S_FETCH`, `S_SRCX`, `S_DSTX`: `MAB = PC`, `MAB_req = 1`. The FSM waits while `MDB_valid` is 0. When `MDB_valid` is set, `PC <= PC + 2` (mod 2^16) and the word goes to `IR`, `SrcExt` or `DstExt` respectively.
- `S_DECODE` is one cycle. It classifies `IR`:
  - `IR[15:13] == 3'b001`: jump. `CAR <= ENTRY_JMP`, go to `S_EXEC`.
  - `IR[15:10] == 6'b000100` and `IR[9:7] != 3'b111`: Format II. Operand is Rs = `IR[3:0]`, As = `IR[5:4]`. RETI (`IR[9:7] == 3'b110`) never takes an extension word.
  - `IR[15:12] >= 4`: Format I. Rs = `IR[11:8]`, As = `IR[5:4]`, Ad = `IR[7]`.
  - Anything else is illegal: pulse `ILLEGAL`, `CAR <= 0`, go to `S_FETCH`.
- Source extension is needed when (As == 01 and Rs != R3) or (As == 11 and Rs == R0). The R3 exclusion covers the constant generator.
- Destination extension is needed when the instruction is Format I and Ad == 1.
- Path after decode: `S_SRCX` if a source extension is needed, then `S_DSTX` if a destination extension is needed, then `S_EXEC`. `CAR` is loaded with the entry point on entering `S_EXEC`.
- `S_EXEC`: if `uop_last` is 0, `CAR <= CAR + 1`.
- When `uop_last` is 1 at the instruction boundary:
  - If `INTREQ & GIE`: `CAR <= ENTRY_INT`, `INTACK` pulses for 1 cycle, stay in `S_EXEC`.
  - Otherwise: `CAR <= 0`, go to `S_FETCH`.
- `pc_load` is honoured only in `S_EXEC`, where it sets `PC <= pc_new`. It is ignored in all other states.
- `SrcExt` and `DstExt` hold their values until overwritten.

## Timing
- Reset (`rst` high at an edge) applies to every output and register: state `S_VEC`, `PC = 0`, `IR = 0`, `CAR = 0`, `SrcExt = DstExt = 0`, `INTACK = ILLEGAL = 0`. From the next cycle `MAB = FFFE` and `MAB_req = 1`.
- `rst` mid-fetch or mid-exec aborts the operation immediately; no partial `PC` update survives.
- `MAB` and `MAB_req` are combinational from state and `PC`.
- `MDB` is sampled on the edge where `MDB_valid = 1`. `MDB_valid` outside the fetch states is ignored.
- With zero-wait memory, a register-only instruction takes 1 (fetch) + 1 (decode) + N exec cycles. Each extension word adds 1 cycle.
- `INTREQ` is sampled only on the `uop_last` cycle. It is never taken mid-instruction or during a fetch.
- `INTACK` is high on the first cycle `CAR == ENTRY_INT`.
- The final step of the interrupt sequence follows the normal boundary rule, so back-to-back interrupts are allowed.
- `CAR` wraps modulo 2^CAR_BITS. The control store guarantees `uop_last` before a wrap.

## Test plan
- Reset vector: `rst` for 2 cycles, then `MDB = 4400` with `MDB_valid = 1` → `MAB = FFFE`, then `PC = 4400`, `MAB = 4400`, `IR = 0`, `CAR = 0`.
- Format I register mode: IR `440A` (MOV R4,R10), `uop_last` on the 2nd exec cycle → `CAR` 1→2, `PC` +2, no ext fetches, back to `S_FETCH`.
- Indexed/indexed: IR `4596`, words `1234`, `0010` → `SrcExt = 1234`, `DstExt = 0010`, `PC` +6, `CAR = 1`. The same run with `MDB_valid` held low 3 cycles on each word → identical result, 6 stall cycles.
- Immediate vs constant generator: IR `5037` → one ext fetch. IR `4315` (R3, As=01) → no ext fetch, straight to `CAR = 1`.
- Interrupt: `INTREQ = 1`, `GIE = 1` on the `uop_last` cycle → `CAR = 50`, `INTACK` high for exactly 1 cycle. With `GIE = 0` → `CAR = 0`, no `INTACK`.
- Illegal/pc_load:
  - IR `0000` → `ILLEGAL` pulses, immediate refetch at `PC + 2`.
  - `pc_load` with `pc_new = C000` during exec → next fetch at `C000`.
  - `pc_load` during `S_FETCH` → ignored.
